// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with registered one-hot grant,
// rotating priority pointer and optional per-grant hold timeout.
module rr_arbiter_8 #(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam int                HOLD_LAST_I = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_LAST_I[HOLD_W-1:0];

    state_t            state, state_n;
    logic [2:0]        ptr, ptr_n;
    logic [2:0]        gnt_id_n;
    logic [7:0]        gnt_n;
    logic [HOLD_W-1:0] hold_cnt, hold_n;
    logic              timeout_n;
    logic [2:0]        win;
    logic [2:0]        idx;
    logic              win_found;

    // Rotated priority encode: scan ptr, ptr+1, ... wrapping modulo 8.
    always_comb begin
        win       = '0;
        idx       = '0;
        win_found = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            idx = ptr + i[2:0];
            if (!win_found && req[idx]) begin
                win       = idx;
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_n   = state;
        gnt_n     = gnt;
        gnt_id_n  = gnt_id;
        ptr_n     = ptr;
        hold_n    = hold_cnt;
        timeout_n = 1'b0;
        case (state)
            IDLE: begin
                if (en && win_found) begin
                    gnt_n    = 8'(1) << win;
                    gnt_id_n = win;
                    hold_n   = '0;
                    state_n  = BUSY;
                end
            end
            BUSY: begin
                if (!req[gnt_id]) begin
                    gnt_n   = '0;
                    ptr_n   = gnt_id + 3'd1;
                    state_n = IDLE;
                end else if (MAX_HOLD != 0 && hold_cnt == HOLD_LAST) begin
                    gnt_n     = '0;
                    ptr_n     = gnt_id + 3'd1;
                    state_n   = IDLE;
                    timeout_n = 1'b1;
                end else if (hold_cnt != '1) begin
                    hold_n = hold_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_id   <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_n;
            gnt      <= gnt_n;
            gnt_id   <= gnt_id_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_n;
            timeout  <= timeout_n;
        end
    end

    assign gnt_valid = |gnt;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed plus randomized checks of rr_arbiter_8 against a cycle-level
// behavioural model of the round-robin/hold/timeout rules.
module tb_rr_arbiter_8;

    localparam int MAX_HOLD = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit       m_busy;
    int       m_owner;
    int       m_ptr;
    int       m_held;
    int       m_gnt_id;
    bit       m_timeout;
    logic [7:0] prev_gnt;

    rr_arbiter_8 #(.MAX_HOLD(MAX_HOLD), .HOLD_W(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .req      (req),
        .gnt      (gnt),
        .gnt_id   (gnt_id),
        .gnt_valid(gnt_valid),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy    = 0;
        m_owner   = 0;
        m_ptr     = 0;
        m_held    = 0;
        m_gnt_id  = 0;
        m_timeout = 0;
        prev_gnt  = '0;
    endtask

    // One clock edge of the rules, applied to the inputs sampled at that edge.
    task automatic model_edge(input logic [7:0] r, input logic e);
        m_timeout = 0;
        if (!m_busy) begin
            if (e && r != 0) begin
                for (int k = 0; k < 8; k++) begin
                    int c;
                    c = (m_ptr + k) % 8;
                    if (r[c]) begin
                        m_owner = c;
                        break;
                    end
                end
                m_busy   = 1;
                m_gnt_id = m_owner;
                m_held   = 1;
            end
        end else if (!r[m_owner]) begin
            m_busy = 0;
            m_ptr  = (m_owner + 1) % 8;
        end else if (MAX_HOLD != 0 && m_held == MAX_HOLD) begin
            m_busy    = 0;
            m_ptr     = (m_owner + 1) % 8;
            m_timeout = 1;
        end else begin
            m_held++;
        end
    endtask

    task automatic check_outputs();
        logic [7:0] exp_gnt;
        exp_gnt = m_busy ? (8'(1) << m_owner) : 8'h00;
        check("gnt", gnt, exp_gnt);
        check("gnt_valid", gnt_valid, m_busy);
        check("timeout", timeout, m_timeout);
        if (m_busy) check("gnt_id", gnt_id, m_gnt_id);
        check("onehot0", $onehot0(gnt), 1);
        if (prev_gnt != 0 && gnt != 0) check("gap", gnt, prev_gnt);
        prev_gnt = gnt;
    endtask

    task automatic step(input logic [7:0] r, input logic e);
        req = r;
        en  = e;
        @(posedge clk);
        model_edge(r, e);
        #1;
        check_outputs();
    endtask

    initial begin
        logic [7:0] rr;
        logic [7:0] flip;
        logic [31:0] rnd;

        rst_n = 1'b0;
        en    = 1'b0;
        req   = '0;
        model_reset();
        #3;
        check("rst_gnt", gnt, 8'h00);
        check("rst_valid", gnt_valid, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Latency and hold
        for (int i = 0; i < 5; i++) step(8'h01, 1'b1);
        step(8'h00, 1'b1);
        // ptr is now 1: req 0x04 wins index 2, then async reset mid-grant
        step(8'h04, 1'b1);
        check("pre_rst_gnt", gnt, 8'h04);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("async_gnt", gnt, 8'h00);
        check("async_id", gnt_id, 3'd0);
        check("async_valid", gnt_valid, 1'b0);
        check("async_timeout", timeout, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        req = '0;

        // Rotation between 0 and 7 with ptr wrap
        for (int it = 0; it < 4; it++) begin
            int h;
            h = (it % 2) ? 7 : 0;
            step(8'h81, 1'b1);
            check("rot_id", gnt_id, h[2:0]);
            step(8'h81, 1'b1);
            rr = 8'h81;
            rr[h] = 1'b0;
            step(rr, 1'b1);
        end

        // Rotated pick from ptr=5 and wrap to 0
        step(8'h10, 1'b1);
        step(8'h00, 1'b1);
        step(8'h23, 1'b1);
        check("ptr5_id", gnt_id, 3'd5);
        step(8'h03, 1'b1);
        step(8'h03, 1'b1);
        check("wrap_id", gnt_id, 3'd0);
        step(8'h02, 1'b1);
        step(8'h02, 1'b1);
        check("next_id", gnt_id, 3'd1);
        step(8'h00, 1'b1);

        // Timeout after exactly MAX_HOLD cycles, then re-grant
        for (int i = 0; i < MAX_HOLD; i++) step(8'h10, 1'b1);
        check("to_held", gnt, 8'h10);
        step(8'h10, 1'b1);
        check("to_pulse", timeout, 1'b1);
        check("to_gnt", gnt, 8'h00);
        step(8'h10, 1'b1);
        check("to_regrant", gnt, 8'h10);
        check("to_clear", timeout, 1'b0);
        step(8'h00, 1'b1);

        // Release on the last allowed cycle is an ordinary release
        for (int i = 0; i < MAX_HOLD; i++) step(8'h08, 1'b1);
        step(8'h00, 1'b1);
        check("late_rel_to", timeout, 1'b0);

        // Enable gating
        for (int i = 0; i < 3; i++) step(8'hFF, 1'b0);
        check("en0_gnt", gnt, 8'h00);
        step(8'hFF, 1'b1);
        step(8'hFF, 1'b0);
        step(8'hFF, 1'b0);
        check("en_drop_hold", gnt_valid, 1'b1);
        rr = 8'hFF;
        rr[m_owner] = 1'b0;
        step(rr, 1'b0);
        for (int i = 0; i < 3; i++) step(8'hFF, 1'b0);
        check("en0_after", gnt, 8'h00);

        // Randomized traffic with persistent requests
        rr = $urandom;
        for (int i = 0; i < 1500; i++) begin
            rnd  = $urandom & $urandom & $urandom;
            flip = rnd[7:0];
            rr   = rr ^ flip;
            step(rr, ($urandom_range(0, 9) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
